// File: rtl/seq_calculator.sv
// Multi-cycle unsigned add/sub/mul/div; add, sub and div-by-zero take 1 cycle, mul/div take WIDTH+1.
// Requests are taken only while o_ready is high; a start during RUN is dropped, not queued.
module seq_calculator #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    input  logic [1:0]       i_Sel,
    output logic             o_ready,
    output logic             o_done,
    output logic [WIDTH-1:0] o_Result,
    output logic [WIDTH-1:0] o_ResultHi,
    output logic             o_Carry,
    output logic             o_DivZero
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_div;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_accept;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_sh;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_div_rem;
    logic [WIDTH-1:0] w_nxt_hi;
    logic [WIDTH-1:0] w_nxt_lo;

    assign o_ready  = (r_state != S_RUN);
    assign o_done   = (r_state == S_DONE);
    assign w_accept = i_start && (r_state != S_RUN);

    // Zero-extended subtract: bit WIDTH is the borrow, i.e. A < B.
    assign w_add = {1'b0, i_A} + {1'b0, i_B};
    assign w_sub = {1'b0, i_A} - {1'b0, i_B};

    // Shift-add multiply: r_hi accumulates, r_lo shifts multiplier out / product in.
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});

    // Restoring divide: r_hi is the partial remainder, r_lo shifts dividend out / quotient in.
    assign w_div_sh  = {r_hi, r_lo[WIDTH-1]};
    assign w_div_ge  = (w_div_sh >= {1'b0, r_b});
    assign w_div_rem = w_div_sh[WIDTH-1:0] - r_b;

    always_comb begin
        w_nxt_hi = w_mul_sum[WIDTH:1];
        w_nxt_lo = {w_mul_sum[0], r_lo[WIDTH-1:1]};
        if (r_div) begin
            w_nxt_hi = w_div_ge ? w_div_rem : w_div_sh[WIDTH-1:0];
            w_nxt_lo = {r_lo[WIDTH-2:0], w_div_ge};
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_div      <= 1'b0;
            r_b        <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            o_Result   <= '0;
            o_ResultHi <= '0;
            o_Carry    <= 1'b0;
            o_DivZero  <= 1'b0;
        end else if (w_accept) begin
            r_div <= i_Sel[0];
            r_b   <= i_B;
            r_hi  <= '0;
            r_lo  <= i_A;
            r_cnt <= CW'(WIDTH);
            case (i_Sel)
                2'b00: begin
                    o_Result   <= w_add[WIDTH-1:0];
                    o_ResultHi <= '0;
                    o_Carry    <= w_add[WIDTH];
                    o_DivZero  <= 1'b0;
                    r_state    <= S_DONE;
                end
                2'b01: begin
                    o_Result   <= w_sub[WIDTH-1:0];
                    o_ResultHi <= '0;
                    o_Carry    <= w_sub[WIDTH];
                    o_DivZero  <= 1'b0;
                    r_state    <= S_DONE;
                end
                2'b10: r_state <= S_RUN;
                default: begin
                    if (i_B == '0) begin
                        o_Result   <= '0;
                        o_ResultHi <= '0;
                        o_Carry    <= 1'b0;
                        o_DivZero  <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
            endcase
        end else begin
            case (r_state)
                S_RUN: begin
                    r_hi  <= w_nxt_hi;
                    r_lo  <= w_nxt_lo;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        o_Result   <= w_nxt_lo;
                        o_ResultHi <= w_nxt_hi;
                        o_Carry    <= r_div ? 1'b0 : (w_nxt_hi != '0);
                        o_DivZero  <= 1'b0;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_calculator.sv
// Checks seq_calculator at WIDTH=8 (directed) and WIDTH=16 (directed + randomised vs arithmetic model).
module tb_seq_calculator;

    logic        clk;
    logic        rst_n;

    logic        start8, ready8, done8, c8, dz8;
    logic [7:0]  a8, b8, res8, hi8;
    logic [1:0]  sel8;

    logic        start16, ready16, done16, c16, dz16;
    logic [15:0] a16, b16, res16, hi16;
    logic [1:0]  sel16;

    int checks = 0;
    int errors = 0;

    seq_calculator #(.WIDTH(8)) dut8 (
        .i_clk(clk), .i_reset_n(rst_n), .i_start(start8), .i_A(a8), .i_B(b8), .i_Sel(sel8),
        .o_ready(ready8), .o_done(done8), .o_Result(res8), .o_ResultHi(hi8),
        .o_Carry(c8), .o_DivZero(dz8)
    );

    seq_calculator #(.WIDTH(16)) dut16 (
        .i_clk(clk), .i_reset_n(rst_n), .i_start(start16), .i_A(a16), .i_B(b16), .i_Sel(sel16),
        .o_ready(ready16), .o_done(done16), .o_Result(res16), .o_ResultHi(hi16),
        .o_Carry(c16), .o_DivZero(dz16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one 8-bit op starting now (just after an edge) and wait for done.
    // scramble: garble operands and pulse i_start while the op is running.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [1:0] sel,
                        input bit scramble, output logic [7:0] res, output logic [7:0] hi,
                        output logic c, output logic dz, output int lat);
        a8 = a; b8 = b; sel8 = sel; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        if (scramble) begin
            a8 = 8'($urandom); b8 = 8'($urandom); sel8 = 2'($urandom);
        end
        lat = 1;
        while (!done8 && lat < 64) begin
            if (scramble) start8 = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        start8 = 1'b0;
        res = res8; hi = hi8; c = c8; dz = dz8;
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic [1:0] sel,
                         output logic [15:0] res, output logic [15:0] hi,
                         output logic c, output logic dz, output int lat);
        a16 = a; b16 = b; sel16 = sel; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        lat = 1;
        while (!done16 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        res = res16; hi = hi16; c = c16; dz = dz16;
    endtask

    // Reference: plain arithmetic on the operands, WIDTH=16.
    function automatic void model16(input int unsigned a, input int unsigned b, input int sel,
                                    output int unsigned res, output int unsigned hi,
                                    output bit c, output bit dz, output int lat);
        longint unsigned p;
        hi = 0; c = 0; dz = 0; lat = 1;
        case (sel)
            0: begin res = (a + b) % 65536; c = (a + b) >= 65536; end
            1: begin res = (a + 65536 - b) % 65536; c = (a < b); end
            2: begin
                p = longint'(a) * longint'(b);
                res = int'(p % 65536); hi = int'(p / 65536); c = (hi != 0); lat = 17;
            end
            default: begin
                if (b == 0) begin res = 0; dz = 1; end
                else begin res = a / b; hi = a % b; lat = 17; end
            end
        endcase
    endfunction

    task automatic test_reset();
        logic [7:0] r, h; logic c, d; int lat;
        checks++;
        if ({ready8, done8, res8, hi8, c8, dz8} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b done=%b res=%0d hi=%0d c=%b dz=%b, want rdy=1 rest 0",
                     ready8, done8, res8, hi8, c8, dz8);
        end
        run8(8'd200, 8'd100, 2'b00, 1'b0, r, h, c, d, lat);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ready8, done8, res8, hi8, c8, dz8} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got rdy=%b done=%b res=%0d hi=%0d c=%b dz=%b, want rdy=1 rest 0",
                     ready8, done8, res8, hi8, c8, dz8);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_addsub();
        logic [7:0] r, h; logic c, d; int lat;
        run8(8'd200, 8'd100, 2'b00, 1'b0, r, h, c, d, lat);
        checks++;
        if ({r, h, c, d} !== {8'd44, 8'd0, 1'b1, 1'b0} || lat != 1) begin
            errors++;
            $display("FAIL add_200_100: got res=%0d hi=%0d c=%b dz=%b lat=%0d, want 44 0 1 0 lat=1", r, h, c, d, lat);
        end
        run8(8'd5, 8'd7, 2'b01, 1'b0, r, h, c, d, lat);
        checks++;
        if ({r, h, c, d} !== {8'd254, 8'd0, 1'b1, 1'b0} || lat != 1) begin
            errors++;
            $display("FAIL sub_5_7: got res=%0d hi=%0d c=%b dz=%b lat=%0d, want 254 0 1 0 lat=1", r, h, c, d, lat);
        end
    endtask

    task automatic test_mul();
        logic [7:0] r, h; logic c, d; int lat; int extra;
        run8(8'd255, 8'd255, 2'b10, 1'b1, r, h, c, d, lat);
        checks++;
        if ({h, r, c, d} !== {8'hFE, 8'h01, 1'b1, 1'b0} || lat != 9) begin
            errors++;
            $display("FAIL mul_255_255: got hi=%h res=%h c=%b dz=%b lat=%0d, want fe 01 1 0 lat=9", h, r, c, d, lat);
        end
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done8) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL single_done: got %0d extra done pulses, want 0", extra);
        end
    endtask

    task automatic test_div();
        logic [7:0] r, h; logic c, d; int lat;
        run8(8'd200, 8'd7, 2'b11, 1'b0, r, h, c, d, lat);
        checks++;
        if ({r, h, c, d} !== {8'd28, 8'd4, 1'b0, 1'b0} || lat != 9) begin
            errors++;
            $display("FAIL div_200_7: got q=%0d r=%0d c=%b dz=%b lat=%0d, want 28 4 0 0 lat=9", r, h, c, d, lat);
        end
        run8(8'd9, 8'd0, 2'b11, 1'b0, r, h, c, d, lat);
        checks++;
        if ({r, h, c, d} !== {8'd0, 8'd0, 1'b0, 1'b1} || lat != 1) begin
            errors++;
            $display("FAIL div_by_zero: got q=%0d r=%0d c=%b dz=%b lat=%0d, want 0 0 0 1 lat=1", r, h, c, d, lat);
        end
        run8(8'd3, 8'd4, 2'b00, 1'b0, r, h, c, d, lat);
        checks++;
        if ({r, h, c, d} !== {8'd7, 8'd0, 1'b0, 1'b0} || lat != 1) begin
            errors++;
            $display("FAIL dz_clear: got res=%0d hi=%0d c=%b dz=%b lat=%0d, want 7 0 0 0 lat=1", r, h, c, d, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] r, h; logic c, d; int lat;
        run8(8'd13, 8'd11, 2'b10, 1'b0, r, h, c, d, lat);
        checks++;
        if ({h, r, c, ready8} !== {8'd0, 8'd143, 1'b0, 1'b1} || lat != 9) begin
            errors++;
            $display("FAIL b2b_first: got hi=%0d res=%0d c=%b rdy=%b lat=%0d, want 0 143 0 1 lat=9", h, r, c, ready8, lat);
        end
        run8(8'd100, 8'd9, 2'b11, 1'b0, r, h, c, d, lat);
        checks++;
        if ({r, h, c, d} !== {8'd11, 8'd1, 1'b0, 1'b0} || lat != 9) begin
            errors++;
            $display("FAIL b2b_second: got q=%0d r=%0d c=%b dz=%b lat=%0d, want 11 1 0 0 lat=9", r, h, c, d, lat);
        end
    endtask

    task automatic test_reset_mid_mul();
        int dones;
        a8 = 8'd77; b8 = 8'd99; sel8 = 2'b10; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ready8, done8, res8, hi8} !== {1'b1, 1'b0, 8'd0, 8'd0}) begin
            errors++;
            $display("FAIL reset_mid_mul: got rdy=%b done=%b res=%0d hi=%0d, want 1 0 0 0", ready8, done8, res8, hi8);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            if (done8 || !ready8) dones++;
        end
        checks++;
        if (dones != 0 || res8 !== 8'd0) begin
            errors++;
            $display("FAIL reset_discard: got %0d busy/done cycles res=%0d, want 0 and res=0", dones, res8);
        end
    endtask

    task automatic test_wide();
        logic [15:0] r, h; logic c, d; int lat;
        run16(16'hFFFF, 16'hFFFF, 2'b10, r, h, c, d, lat);
        checks++;
        if ({h, r, c} !== {32'hFFFE0001, 1'b1} || lat != 17) begin
            errors++;
            $display("FAIL mul16_max: got %h%h c=%b lat=%0d, want fffe0001 c=1 lat=17", h, r, c, lat);
        end
    endtask

    task automatic test_random();
        logic [15:0] r, h; logic c, d; int lat;
        int unsigned a, b, er, eh; bit ec, ed; int el; int sel;
        for (int n = 0; n < 1000; n++) begin
            sel = int'($urandom_range(0, 3));
            a = $urandom_range(0, 65535);
            b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 65535);
            model16(a, b, sel, er, eh, ec, ed, el);
            run16(16'(a), 16'(b), 2'(sel), r, h, c, d, lat);
            checks++;
            if (32'(r) !== er || 32'(h) !== eh || c !== ec || d !== ed || lat != el) begin
                errors++;
                $display("FAIL rand16 #%0d sel=%0d a=%0d b=%0d: got res=%0d hi=%0d c=%b dz=%b lat=%0d, want %0d %0d %b %b lat=%0d",
                         n, sel, a, b, r, h, c, d, lat, er, eh, ec, ed, el);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; sel8 = '0;
        start16 = 1'b0; a16 = '0; b16 = '0; sel16 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_reset();
        test_addsub();
        test_mul();
        test_div();
        test_back_to_back();
        test_reset_mid_mul();
        test_wide();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
